// File: rtl/sdramtx_pkg.sv
// Shared encodings and entry layout for the SDRAM write-data packer.
package sdramtx_pkg;

  localparam int PM_PHASE    = 0;
  localparam int PM_TWOBEAT  = 1;
  localparam int PM_FASTPACK = 2;

  // Channel word positions inside one FIFO entry {state, slow, fast}.
  localparam int SLOT_FAST  = 0;
  localparam int SLOT_SLOW  = 1;
  localparam int SLOT_STATE = 2;

  function automatic int entry_width(input int ch_w);
    return 3 * ch_w;
  endfunction

endpackage

// File: rtl/sdramtx_fifo.sv
// Synchronous FIFO with a two-deep head view and pop-1/pop-2 controls.
module sdramtx_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop1,
  input  logic                     pop2,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [1:0]       pop_cnt;

  // The caller guarantees push only when not full and pops only with enough data.
  assign pop_cnt = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      rptr  <= rptr + AW'(pop_cnt);
      level <= level + LW'(push) - LW'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign head      = mem[rptr];
  assign head_next = mem[rptr + AW'(1)];
  assign full      = (level == LW'(DEPTH));

endmodule

// File: rtl/sdramtx_pack.sv
// SDRAM write-data packer: buffers AVC vectors and serves 2*CH_W-bit DQ beats
// in phase-select, two-beat or fast-pack mode.
module sdramtx_pack
  import sdramtx_pkg::*;
#(
  parameter int CH_W      = 16,
  parameter int DEPTH     = 8,
  parameter int PACK_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_fast,
  input  logic [CH_W-1:0]         in_slow,
  input  logic [CH_W-1:0]         in_state,
  input  logic                    burst_start,
  input  logic                    dq_req,
  output logic [2*CH_W-1:0]       dq_out,
  output logic                    dq_valid,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    underrun
);

  localparam int EW = entry_width(CH_W);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [EW-1:0]     wdata;
  logic [EW-1:0]     head;
  logic [EW-1:0]     head_next;
  logic              full;
  logic              push;
  logic              pop1;
  logic              pop2;
  logic              sufficient;
  logic              serve;
  logic [1:0]        bcnt;
  logic [1:0]        eff_bcnt;
  logic              sb;
  logic              sb_next;
  logic [2*CH_W-1:0] beat;
  logic [CH_W-1:0]   head_fast;
  logic [CH_W-1:0]   head_slow;
  logic [CH_W-1:0]   head_state;
  logic [CH_W-1:0]   next_fast;
  logic              unused_next;

  assign in_ready = reset && !full;
  assign push     = in_valid && in_ready;

  always_comb begin
    wdata = '0;
    wdata[SLOT_FAST*CH_W  +: CH_W] = in_fast;
    wdata[SLOT_SLOW*CH_W  +: CH_W] = in_slow;
    wdata[SLOT_STATE*CH_W +: CH_W] = in_state;
  end

  sdramtx_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .wdata     (wdata),
    .pop1      (pop1),
    .pop2      (pop2),
    .head      (head),
    .head_next (head_next),
    .level     (level),
    .full      (full)
  );

  assign head_fast   = head[SLOT_FAST*CH_W  +: CH_W];
  assign head_slow   = head[SLOT_SLOW*CH_W  +: CH_W];
  assign head_state  = head[SLOT_STATE*CH_W +: CH_W];
  assign next_fast   = head_next[SLOT_FAST*CH_W +: CH_W];
  assign unused_next = ^head_next;

  assign sufficient = (PACK_MODE == PM_FASTPACK) ? (level >= LW'(2)) : (level != '0);
  assign serve      = dq_req && sufficient;
  // A concurrent burst_start makes this very beat the first of the new burst.
  assign eff_bcnt   = burst_start ? 2'b00 : bcnt;

  always_comb begin
    beat    = '0;
    pop1    = 1'b0;
    pop2    = 1'b0;
    sb_next = sb;
    case (PACK_MODE)
      PM_TWOBEAT: begin
        beat = sb ? {head_state, head_fast} : {head_slow, head_fast};
        if (serve) begin
          pop1    = sb;
          sb_next = !sb;
        end
      end
      PM_FASTPACK: begin
        beat = {next_fast, head_fast};
        pop2 = serve;
      end
      default: begin
        beat = {(eff_bcnt == 2'b10) ? head_slow : head_state, head_fast};
        pop1 = serve;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt     <= 2'b00;
      sb       <= 1'b0;
      dq_out   <= '0;
      dq_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      dq_valid <= serve;
      sb       <= sb_next;
      if (serve) begin
        dq_out <= beat;
        bcnt   <= eff_bcnt + 2'd1;
      end else if (burst_start) begin
        bcnt   <= 2'b00;
      end
      if (dq_req && !sufficient) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdramtx_pack.sv
// Directed bench for sdramtx_pack: one instance per packing mode on shared stimulus.
module tb_sdramtx_pack;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_fast;
  logic [15:0] in_slow;
  logic [15:0] in_state;
  logic        burst_start;
  logic        dq_req;

  logic        rdy0, rdy1, rdy2;
  logic [31:0] dq0, dq1, dq2;
  logic        val0, val1, val2;
  logic [3:0]  lvl0, lvl1, lvl2;
  logic        und0, und1, und2;

  int total = 0;
  int bad   = 0;

  sdramtx_pack #(.CH_W(16), .DEPTH(8), .PACK_MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .in_fast(in_fast), .in_slow(in_slow), .in_state(in_state),
    .burst_start(burst_start), .dq_req(dq_req), .dq_out(dq0),
    .dq_valid(val0), .level(lvl0), .underrun(und0));

  sdramtx_pack #(.CH_W(16), .DEPTH(8), .PACK_MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .in_fast(in_fast), .in_slow(in_slow), .in_state(in_state),
    .burst_start(burst_start), .dq_req(dq_req), .dq_out(dq1),
    .dq_valid(val1), .level(lvl1), .underrun(und1));

  sdramtx_pack #(.CH_W(16), .DEPTH(8), .PACK_MODE(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
    .in_fast(in_fast), .in_slow(in_slow), .in_state(in_state),
    .burst_start(burst_start), .dq_req(dq_req), .dq_out(dq2),
    .dq_valid(val2), .level(lvl2), .underrun(und2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rst;
    int          sel;
    bit          vin;
    logic [15:0] f;
    logic [15:0] s;
    logic [15:0] st;
    bit          bs;
    bit          rq;
    bit          ev;
    logic [31:0] edq;
    logic [3:0]  elv;
    bit          eun;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, int sel, bit vin, logic [15:0] f, logic [15:0] s,
                              logic [15:0] st, bit bs, bit rq, bit ev, logic [31:0] edq,
                              logic [3:0] elv, bit eun);
    vec_t v;
    v.rst = rst; v.sel = sel; v.vin = vin; v.f = f; v.s = s; v.st = st;
    v.bs = bs; v.rq = rq; v.ev = ev; v.edq = edq; v.elv = elv; v.eun = eun;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_fast = '0; in_slow = '0; in_state = '0;
    burst_start = 1'b0; dq_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic push_vec(input logic [15:0] f, input logic [15:0] s, input logic [15:0] st);
    in_valid = 1'b1; in_fast = f; in_slow = s; in_state = st;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic req_beat(input bit bs);
    dq_req = 1'b1; burst_start = bs;
    @(posedge clk);
    #1;
    dq_req = 1'b0; burst_start = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    if (v.rst) do_reset();
    in_valid = v.vin; in_fast = v.f; in_slow = v.s; in_state = v.st;
    burst_start = v.bs; dq_req = v.rq;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic check_output(input int idx, input vec_t v);
    logic [31:0] d;
    logic        va;
    logic [3:0]  l;
    logic        u;
    case (v.sel)
      1:       begin d = dq1; va = val1; l = lvl1; u = und1; end
      2:       begin d = dq2; va = val2; l = lvl2; u = und2; end
      default: begin d = dq0; va = val0; l = lvl0; u = und0; end
    endcase
    check($sformatf("row%0d dq_out", idx), d, v.edq);
    check($sformatf("row%0d dq_valid", idx), {31'b0, va}, {31'b0, v.ev});
    check($sformatf("row%0d level", idx), {28'b0, l}, {28'b0, v.elv});
    check($sformatf("row%0d underrun", idx), {31'b0, u}, {31'b0, v.eun});
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;

    // Mode 0 phase-select: upper half follows bcnt 0,1,2,3.
    tbl.push_back(mk(1, 0, 1, 16'h1111, 16'hA001, 16'h5001, 0, 0, 0, 32'h0, 4'd1, 0));
    tbl.push_back(mk(0, 0, 1, 16'h2222, 16'hA002, 16'h5002, 0, 0, 0, 32'h0, 4'd2, 0));
    tbl.push_back(mk(0, 0, 1, 16'h3333, 16'hA003, 16'h5003, 0, 0, 0, 32'h0, 4'd3, 0));
    tbl.push_back(mk(0, 0, 1, 16'h4444, 16'hA004, 16'h5004, 0, 0, 0, 32'h0, 4'd4, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 0, 0, 32'h0, 4'd4, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 32'h5001_1111, 4'd3, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 32'h5002_2222, 4'd2, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 32'hA003_3333, 4'd1, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 32'h5004_4444, 4'd0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 32'h5004_4444, 4'd0, 0));
    // Mode 1 two-beat: slow beat, then state beat with pop; then underrun.
    tbl.push_back(mk(1, 1, 1, 16'h0101, 16'h0B01, 16'h0C01, 0, 0, 0, 32'h0, 4'd1, 0));
    tbl.push_back(mk(0, 1, 1, 16'h0202, 16'h0B02, 16'h0C02, 0, 0, 0, 32'h0, 4'd2, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 32'h0B01_0101, 4'd2, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 32'h0C01_0101, 4'd1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 32'h0B02_0202, 4'd1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 32'h0C02_0202, 4'd0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 32'h0C02_0202, 4'd0, 1));
    // Mode 2 fast-pack: two fast words per beat, underrun with one left.
    tbl.push_back(mk(1, 2, 1, 16'h1001, 16'hEEEE, 16'hEEEE, 0, 0, 0, 32'h0, 4'd1, 0));
    tbl.push_back(mk(0, 2, 1, 16'h1002, 16'hEEEE, 16'hEEEE, 0, 0, 0, 32'h0, 4'd2, 0));
    tbl.push_back(mk(0, 2, 1, 16'h1003, 16'hEEEE, 16'hEEEE, 0, 0, 0, 32'h0, 4'd3, 0));
    tbl.push_back(mk(0, 2, 0, 16'h0, 16'h0, 16'h0, 0, 1, 1, 32'h1002_1001, 4'd1, 0));
    tbl.push_back(mk(0, 2, 0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 32'h1002_1001, 4'd1, 1));

    #2;
    check("reset in_ready", {31'b0, rdy0}, 32'd0);
    check("reset dq_valid", {31'b0, val0}, 32'd0);
    check("reset level", {28'b0, lvl0}, 32'd0);
    check("reset dq_out", dq0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("release in_ready", {31'b0, rdy0}, 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i]);
      check_output(i, tbl[i]);
    end

    // Fill to DEPTH with in_valid held; the 9th vector waits for a pop.
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_fast = 16'(k);
      @(posedge clk);
      #1;
    end
    check("full level", {28'b0, lvl0}, 32'd8);
    check("full in_ready", {31'b0, rdy0}, 32'd0);
    in_fast = 16'd9;
    @(posedge clk);
    #1;
    check("refused level", {28'b0, lvl0}, 32'd8);
    dq_req = 1'b1;
    @(posedge clk);
    #1;
    dq_req = 1'b0;
    check("pop from full level", {28'b0, lvl0}, 32'd7);
    check("pop from full in_ready", {31'b0, rdy0}, 32'd1);
    check("pop from full beat", {16'b0, dq0[15:0]}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ninth stored level", {28'b0, lvl0}, 32'd8);
    dq_req = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("drain%0d fast", k), {16'b0, dq0[15:0]}, 32'(k));
      check($sformatf("drain%0d valid", k), {31'b0, val0}, 32'd1);
    end
    dq_req = 1'b0;
    check("drained level", {28'b0, lvl0}, 32'd0);

    // Reset between the two beats of mode 1.
    do_reset();
    push_vec(16'h0301, 16'h0B03, 16'h0C03);
    req_beat(1'b0);
    check("pre-reset slow beat", dq1, 32'h0B03_0301);
    reset = 1'b0;
    #2;
    check("mid reset dq_out", dq1, 32'd0);
    check("mid reset dq_valid", {31'b0, val1}, 32'd0);
    check("mid reset level", {28'b0, lvl1}, 32'd0);
    check("mid reset in_ready", {31'b0, rdy1}, 32'd0);
    check("mid reset underrun", {31'b0, und1}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_vec(16'h0401, 16'h0B04, 16'h0C04);
    req_beat(1'b0);
    check("post-reset slow beat", dq1, 32'h0B04_0401);
    req_beat(1'b0);
    check("post-reset state beat", dq1, 32'h0C04_0401);
    check("post-reset level", {28'b0, lvl1}, 32'd0);

    // burst_start together with dq_req at bcnt=2 in mode 0.
    do_reset();
    for (int k = 1; k <= 5; k++)
      push_vec(16'h0600 + 16'(k), 16'hA060 + 16'(k), 16'h5060 + 16'(k));
    req_beat(1'b0);
    check("bs beat0", dq0, 32'h5061_0601);
    req_beat(1'b0);
    check("bs beat1", dq0, 32'h5062_0602);
    req_beat(1'b1);
    check("bs restart beat", dq0, 32'h5063_0603);
    req_beat(1'b0);
    check("bs after restart", dq0, 32'h5064_0604);
    req_beat(1'b0);
    check("bs phase two", dq0, 32'hA065_0605);
    check("bs underrun", {31'b0, und0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdramtx_pack.md
# sdramtx_pack

Parametrised SDRAM write-data packer. It sits between the SD-card AVC vector parser and the SDRAM controller. It buffers AVC vectors (fast word, slow tri-state word, state word) in a small FIFO and presents them as 2×CH_W-bit DQ beats when the controller requests them. It replaces fixed-width direct latching with a configurable width, FIFO depth and packing mode, a valid/ready input handshake, burst-phase tracking and underrun/level reporting.

## Interface
- `CH_W`, 16: width of each channel word; DQ width = 2×CH_W.
- `DEPTH`, 8: FIFO entries; power of 2, ≥2.
- `PACK_MODE`, 0: 0 = phase-select, 1 = two-beat, 2 = fast-pack.

Ports:
- `clk`  in  1  SDRAM clock; all registers on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  parser has a vector.
- `in_ready`  out  1  FIFO can accept; = !full, forced 0 while reset low.
- `in_fast`  in  CH_W  fast non-tri-state signals.
- `in_slow`  in  CH_W  slow tri-state signals.
- `in_state`  in  CH_W  tri-state enables for slow signals.
- `burst_start`  in  1  controller begins a new write burst; clears beat counter.
- `dq_req`  in  1  controller takes one beat this cycle.
- `dq_out`  out  2×CH_W  beat data to SDRAM DQ.
- `dq_valid`  out  1  dq_out holds a fresh beat.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `underrun`  out  1  sticky: dq_req with insufficient data.

## Operation
- FIFO entry = {state, slow, fast}, 3×CH_W bits. Push when in_valid && in_ready. No bypass: a push and a pop in the same cycle operate on pre-cycle contents. level changes by +1, −1 or 0 accordingly.
- Beat counter `bcnt` is 2 bits. It increments (wraps 3→0) on every served beat. burst_start sets it to 0; if dq_req is asserted in the same cycle, that beat uses bcnt=0 and bcnt becomes 1.
- Data is sufficient when level ≥1 (modes 0 and 1) or level ≥2 (mode 2).
- Mode 0: beat = {bcnt==2'b10 ? slow : state, fast} from the head entry; pop 1 entry per beat.
- Mode 1: a sub-beat flag `sb` selects the beat. sb=0 gives {slow, fast} with no pop, and sb toggles to 1. sb=1 gives {state, fast}, pops the entry, and sb toggles to 0. burst_start does not touch sb.
- Mode 2: beat = {fast of head+1, fast of head}; pop 2 entries. slow/state are discarded.
- dq_req with insufficient data: no pop, no counter change, dq_out holds its previous value, dq_valid=0, underrun set to 1. underrun clears only on reset.
- Reset (async, any time, including mid-burst or mid two-beat): pointers, level, bcnt, sb, dq_out=0, dq_valid=0, underrun=0, in_ready=0. in_ready becomes 1 in the first cycle after reset deasserts. In-flight data is lost.

## Timing
- Write-to-visible: an entry pushed at edge t can be served by a dq_req sampled at edge t+1.
- Read latency: dq_req sampled at edge t gives dq_out/dq_valid registered at edge t, valid for cycle t+1. dq_valid is a 1-cycle pulse per served beat. Back-to-back dq_req gives one beat per cycle.
- in_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.
- Full and dq_req in the same cycle: the pop happens but the push is refused (in_ready was 0).

## Structure
- Package `sdramtx_pkg`: PACK_MODE encodings (PM_PHASE=0, PM_TWOBEAT=1, PM_FASTPACK=2), function returning entry width 3×CH_W, and slot index constants for fast/slow/state.
- Sub-module `sdramtx_fifo`: parametrised synchronous FIFO (width, depth). It provides 2-deep head read (head, head+1) and pop-1/pop-2 inputs. The packer logic, bcnt, sb and flags live in the top.

## Test plan
- Mode 0, CH_W=16: push 4 vectors (fast=0x1111·k, slow=0xA000+k, state=0x5000+k, k=1..4), burst_start, then 4 dq_req. The beats' upper halves must be 0x5001, 0x5002, 0xA003, 0x5004, with the lower halves matching each fast word.
- Mode 1: push 2 vectors, 4 dq_req. Beats must be {slow1,fast1}, {state1,fast1}, {slow2,fast2}, {state2,fast2}, and level must go 2→2→1→1→0.
- Mode 2: push 3 vectors, 2 dq_req. The first beat is {fast2,fast1}. The second dq_req gives dq_valid=0 and underrun=1, and level stays 1.
- DEPTH=8: push 8 with in_valid held high. in_ready must fall after the 8th push and the 9th vector must not be stored. One dq_req then lets the 9th in, giving level=8.
- Reset asserted low between the two beats of mode 1. All outputs must be 0 and level must be 0. After release, push 1 vector and 2 dq_req: the beats are the slow beat first, then the state beat.
- burst_start concurrent with dq_req at bcnt=2: the served beat uses state (bcnt=0) and the next beat uses bcnt=1.
